// File: rtl/serial_op_sched_pkg.sv
// Shared types and constants for the serial XOR scheduler (serial_op_sched).
package serial_op_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int LAT = 5;

  typedef enum logic [2:0] {
    IDLE,
    C0,
    C1,
    C2,
    C3,
    DONE
  } sched_state_t;

endpackage

// File: rtl/serial_op_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// found searching upward (with wrap) from ptr_i.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  input  logic                 en_i,
  output logic [N-1:0]         gnt_o
);

  localparam int PW = $clog2(N);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_op_sched.sv
// Round-robin scheduler feeding a shared AND/NOT stage that builds A^B over four cycles.
// Optional ops_done counter is enabled by defining SERIAL_OP_SCHED_STATS_EN.
module serial_op_sched
  import serial_op_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
  output logic [NREQ-1:0]             req_ready,
  output logic                        rsp_valid,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic [WIDTH-1:0]            rsp_xo
`ifdef SERIAL_OP_SCHED_STATS_EN
  ,
  output logic [15:0]                 ops_done
`endif
);

  localparam int IDW = $clog2(NREQ);

  sched_state_t   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] m0_q, m0_d, m1_q, m1_d;

  logic [IDW-1:0]   gnt_idx;
  logic             accept;
  logic [WIDTH-1:0] op_x, op_y, alu;
  logic             op_inv;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (req_ready)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) gnt_idx = IDW'(i);
    end
  end

  assign accept = |(req_valid & req_ready);

  // Operand steering for the single shared stage; kept apart from the
  // next-state logic so the stage output never feeds back into its own select.
  always_comb begin
    op_x   = '0;
    op_y   = '0;
    op_inv = 1'b0;
    unique case (state_q)
      C0:      begin op_x = b_q;  op_inv = 1'b1; end
      C1:      begin op_x = m0_q; op_y = a_q;   end
      C2:      begin op_x = a_q;  op_inv = 1'b1; end
      C3:      begin op_x = m1_q; op_y = b_q;   end
      default: ;
    endcase
  end

  assign alu = op_inv ? ~op_x : (op_x & op_y);

  always_comb begin
    // NOTE: every next-state value gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    m0_d    = m0_q;
    m1_d    = m1_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = C0;
          a_d     = req_a[gnt_idx];
          b_d     = req_b[gnt_idx];
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      C0:      begin m0_d = alu; state_d = C1; end
      C1:      begin m0_d = alu; state_d = C2; end
      C2:      begin m1_d = alu; state_d = C3; end
      C3:      begin m1_d = alu; state_d = DONE; end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m0_q    <= '0;
      m1_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
    end
  end

  // Gated by rst so a reset landing on DONE never emits a strobe.
  assign rsp_valid = (state_q == DONE) && !rst;
  assign rsp_xo    = rsp_valid ? (m0_q | m1_q) : '0;
  assign rsp_id    = rsp_valid ? id_q : '0;

`ifdef SERIAL_OP_SCHED_STATS_EN
  logic [15:0] ops_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done_q <= '0;
    end else if (rsp_valid && (ops_done_q != 16'hFFFF)) begin
      ops_done_q <= ops_done_q + 16'd1;
    end
  end

  assign ops_done = ops_done_q;
`endif

endmodule
